// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle for fir_mac_sequencer: sample in/out handshakes, coefficient port, multiplier operands.
// slave = the sequencer itself; master = whatever drives samples/coefficients and hosts the multiplier.
// Clock and reset are kept outside the bundle.
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic signed [15:0]       in_sample;
  logic                     in_ready;
  logic                     coef_we;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [15:0]       coef_data;
  logic signed [15:0]       mult_a;
  logic signed [15:0]       mult_b;
  logic signed [31:0]       mult_p;
  logic                     out_valid;
  logic signed [15:0]       out_sample;
  logic                     busy;

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data, mult_p,
    output in_ready, mult_a, mult_b, out_valid, out_sample, busy
  );

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data, mult_p,
    input  in_ready, mult_a, mult_b, out_valid, out_sample, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer: owns delay line + coefficients, feeds one external 16x16 multiplier a tap per cycle.
// Latency: out_valid TAPS+2 edges after the accept edge; one sample per TAPS+3 cycles back to back.
// Backpressure: in_ready only in IDLE, source holds the sample. FIR_SAT_EN selects saturating output (else wrap).
module fir_mac_sequencer #(
  parameter int TAPS   = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  fir_mac_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

  localparam logic [ADDR_W-1:0]       LAST_K  = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(1 << (SHIFT - 1));

  state_t                    state_q, state_d;
  logic        [ADDR_W-1:0]  wr_ptr_q;
  logic        [ADDR_W-1:0]  k_q;
  logic                      pending_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [15:0]        mult_a_q, mult_b_q;
  logic                      out_valid_q;
  logic signed [15:0]        out_sample_q;
  logic signed [15:0]        dly_q  [TAPS];
  logic signed [15:0]        coef_q [TAPS];

  logic                      accept;
  logic        [ADDR_W-1:0]  rd_idx;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [15:0]        sat16;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  // newest sample sits one behind the write pointer; walk backwards in time with k
  assign rd_idx   = wr_ptr_q - ADDR_W'(1) - k_q;
  assign prod_ext = {{(ACC_W-32){bus.mult_p[31]}}, bus.mult_p};
  assign rnd      = acc_q + RND_C;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
  logic signed [ACC_W-1:0] shf;
  assign shf = rnd >>> SHIFT;

  // clamp the rounded, scaled accumulator into the 16-bit output range
  always_comb begin
    sat16 = shf[15:0];
    if (shf > SAT_MAX)      sat16 = 16'sh7fff;
    else if (shf < SAT_MIN) sat16 = 16'sh8000;
  end
`else
  assign sat16 = 16'(rnd >>> SHIFT);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: one tap per RUN cycle, then one cycle to absorb the last product, one to emit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_q == LAST_K) state_d = FLUSH;
      FLUSH:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: delay line, coefficient bank, operand registers, accumulator and output
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      k_q          <= '0;
      pending_q    <= 1'b0;
      acc_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dly_q[wr_ptr_q] <= bus.in_sample;
            wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            acc_q           <= '0;
            k_q             <= '0;
            pending_q       <= 1'b0;
          end else if (bus.coef_we) begin
            // accept has priority over a same-edge coefficient write
            coef_q[bus.coef_addr] <= bus.coef_data;
          end
        end
        RUN: begin
          mult_a_q  <= dly_q[rd_idx];
          mult_b_q  <= coef_q[k_q];
          // the product on mult_p belongs to the operands issued on the previous edge
          if (pending_q) acc_q <= acc_q + prod_ext;
          pending_q <= 1'b1;
          k_q       <= k_q + ADDR_W'(1);
        end
        FLUSH: acc_q <= acc_q + prod_ext;
        OUT: begin
          out_sample_q <= sat16;
          out_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a zero-latency multiplier model and hand-computed results.
// Drives inputs and samples outputs 1 time unit after each rising edge.
// Build with FIR_SAT_EN to match a saturating DUT build.
module tb_fir_mac_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fir_mac_sequencer_if #(.ADDR_W(4)) bus ();

  assign bus.mult_p = $signed(bus.mult_a) * $signed(bus.mult_b);

  fir_mac_sequencer #(.TAPS(16), .ADDR_W(4), .ACC_W(40), .SHIFT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIR_SAT_EN
  localparam longint SAT16_EXP = 32767;
`else
  localparam longint SAT16_EXP = -32;   // 0xFFE0: low 16 bits of 524256
`endif

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_coef(input int k, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(k);
    bus.coef_data = 16'(v);
    tick();
    bus.coef_we   = 1'b0;
  endtask

  // wait for the out_valid pulse; lat counts edges since the accept edge
  task automatic wait_out(input string tag, input int lat0, output longint res, output int lat);
    int seen;
    seen = 0;
    lat  = lat0;
    res  = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      tick();
      lat++;
      if (bus.out_valid) begin
        seen = 1;
        res  = longint'(bus.out_sample);
      end
    end
    if (seen == 0) check_eq({tag, "_timeout"}, seen, 1);
  endtask

  task automatic send_sample(input string tag, input int s, output longint res, output int lat);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check_eq({tag, "_rdy_timeout"}, 0, 1);
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'(s);
    tick();
    bus.in_valid  = 1'b0;
    wait_out(tag, 0, res, lat);
  endtask

  initial begin
    longint res;
    int     lat;
    int     accepts, pulses, t0, t1, wide, rdy_bad, prev_ov, seen_ov;
    longint first_hs;

    n_checks = 0;
    n_errors = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    // reset state
    do_reset();
    check_eq("rst_busy",     bus.busy,       0);
    check_eq("rst_in_ready", bus.in_ready,   1);
    check_eq("rst_out_vld",  bus.out_valid,  0);
    check_eq("rst_out_smp",  bus.out_sample, 0);
    check_eq("rst_mult_a",   bus.mult_a,     0);
    check_eq("rst_mult_b",   bus.mult_b,     0);

    // single tap: 32767 * 0.5 rounds to 16384, 18 edges after accept
    write_coef(0, 16384);
    send_sample("single", 32767, res, lat);
    check_eq("single_out", res, 16384);
    check_eq("single_lat", lat, 18);

    // coefficient write during RUN is ignored
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sd32767;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    tick();
    tick();
    check_eq("busy_mid_run", bus.busy, 1);
    write_coef(0, 0);
    wait_out("wr_busy", 4, res, lat);
    check_eq("wr_busy_out", res, 16384);
    // same write in IDLE takes effect
    write_coef(0, 0);
    send_sample("wr_idle", 32767, res, lat);
    check_eq("wr_idle_out", res, 0);
    write_coef(0, 16384);

    // accept and coef_we on the same edge: write dropped
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sd32767;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 16'sd0;
    tick();
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    wait_out("coll", 1, res, lat);
    check_eq("coll_out", res, 16384);
    send_sample("coll2", 32767, res, lat);
    check_eq("coll2_out", res, 16384);

    // handshake: in_valid held 30 cycles -> accepts at edges 0 and 19, pulses 19 apart
    accepts = 0; pulses = 0; t0 = 0; t1 = 0; wide = 0; rdy_bad = 0; prev_ov = 0;
    first_hs = 0;
    bus.in_sample = 16'sd100;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.busy == bus.in_ready) rdy_bad++;
      tick();
      if (bus.out_valid) begin
        if (pulses == 0) begin
          t0 = i;
          first_hs = longint'(bus.out_sample);
        end else begin
          t1 = i;
        end
        pulses++;
        if (prev_ov != 0) wide++;
      end
      prev_ov = int'(bus.out_valid);
    end
    check_eq("hs_accepts", accepts, 2);
    check_eq("hs_pulses",  pulses,  2);
    check_eq("hs_spacing", t1 - t0, 19);
    check_eq("hs_first_t", t0, 18);
    check_eq("hs_wide",    wide,    0);
    check_eq("hs_rdy_busy", rdy_bad, 0);
    check_eq("hs_out",     first_hs, 50);

    // impulse response
    do_reset();
    write_coef(0, 8192);
    write_coef(1, 16384);
    write_coef(2, -8192);
    send_sample("imp0", 32767, res, lat);
    check_eq("imp0_out", res, 8192);
    send_sample("imp1", 0, res, lat);
    check_eq("imp1_out", res, 16384);
    send_sample("imp2", 0, res, lat);
    check_eq("imp2_out", res, -8192);
    send_sample("imp3", 0, res, lat);
    check_eq("imp3_out", res, 0);

    // full-scale: 16th output = 16*32767^2 rounded >>15 = 524256 -> sat or wrap
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, 32767);
    for (int n = 0; n < 16; n++) begin
      send_sample("sat", 32767, res, lat);
      if (n == 0)  check_eq("sat_first", res, 32766);
      if (n == 15) check_eq("sat_last",  res, SAT16_EXP);
    end

    // reset mid-run at E5 (delay line currently full of 32767)
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sd32767;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_busy",     bus.busy,      0);
    check_eq("mrst_in_ready", bus.in_ready,  1);
    seen_ov = int'(bus.out_valid);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid) seen_ov = 1;
    end
    check_eq("mrst_no_pulse", seen_ov, 0);
    write_coef(0, 16384);
    write_coef(1, 16384);
    send_sample("mrst", 32767, res, lat);
    check_eq("mrst_out", res, 16384);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
